// File: rtl/inst_fifo_if.sv
// Fetch/decode handshake bundle for the dual-issue instruction buffer.
// The master modport is the fetch/decode side; the slave modport is the FIFO itself.
interface inst_fifo_if #(
  parameter int PTR_W = 4
);
  logic             write_en1;
  logic             write_en2;
  logic [31:0]      write_inst1;
  logic [31:0]      write_addr1;
  logic [31:0]      write_inst2;
  logic [31:0]      write_addr2;

  logic             read_en1;
  logic             read_en2;
  logic [31:0]      read_inst1;
  logic [31:0]      read_addr1;
  logic [31:0]      read_inst2;
  logic [31:0]      read_addr2;
  logic             read_ok1;
  logic             read_ok2;

  logic             empty;
  logic             almost_empty;
  logic             full;
  logic [PTR_W:0]   count;

  modport master (
    output write_en1, write_en2, write_inst1, write_addr1, write_inst2, write_addr2,
    output read_en1, read_en2,
    input  read_inst1, read_addr1, read_inst2, read_addr2, read_ok1, read_ok2,
    input  empty, almost_empty, full, count
  );

  modport slave (
    input  write_en1, write_en2, write_inst1, write_addr1, write_inst2, write_addr2,
    input  read_en1, read_en2,
    output read_inst1, read_addr1, read_inst2, read_addr2, read_ok1, read_ok2,
    output empty, almost_empty, full, count
  );
endinterface

// File: rtl/inst_fifo.sv
// Dual-write / dual-read show-ahead instruction buffer between fetch and decode.
// Entries are {pc, instruction}; head and head+1 are presented combinationally.
module inst_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fifo_rst,
  inst_fifo_if.slave bus
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];

  logic [1:0]       npush;
  logic [1:0]       npop;
  logic             full_w;
  logic [PTR_W-1:0] wr_ptr_nx;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [63:0]      head1;
  logic [63:0]      head2;

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens room for a push; the whole fetched pair is dropped instead.
  assign full_w    = (count_q >= CNT_FULL);
  assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);

  always_comb begin
    npop = 2'd0;
    if (bus.read_en1 && bus.read_en2 && (count_q >= CNT_TWO)) begin
      npop = 2'd2;
    end else if (bus.read_en1 && (count_q >= CNT_ONE)) begin
      npop = 2'd1;
    end
  end

  always_comb begin
    npush = 2'd0;
    if (!full_w && bus.write_en1) begin
      npush = bus.write_en2 ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(npush);
    rd_ptr_d = rd_ptr_q + PTR_W'(npop);
    count_d  = count_q + CNT_W'(npush) - CNT_W'(npop);
    if (fifo_rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Slot 2 lands at wr_ptr+1, which wraps naturally to index 0 at the top.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (!fifo_rst) begin
      if (npush != 2'd0) begin
        mem_d[wr_ptr_q] = {bus.write_addr1, bus.write_inst1};
      end
      if (npush == 2'd2) begin
        mem_d[wr_ptr_nx] = {bus.write_addr2, bus.write_inst2};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign head1 = mem_q[rd_ptr_q];
  assign head2 = mem_q[rd_ptr_nx];

  // Read data is zeroed whenever its valid is low so decode never sees stale words.
  always_comb begin
    bus.read_ok1     = (count_q >= CNT_ONE);
    bus.read_ok2     = (count_q >= CNT_TWO);
    bus.read_addr1   = 32'd0;
    bus.read_inst1   = 32'd0;
    bus.read_addr2   = 32'd0;
    bus.read_inst2   = 32'd0;
    if (bus.read_ok1) begin
      bus.read_addr1 = head1[63:32];
      bus.read_inst1 = head1[31:0];
    end
    if (bus.read_ok2) begin
      bus.read_addr2 = head2[63:32];
      bus.read_inst2 = head2[31:0];
    end
    bus.empty        = (count_q == '0);
    bus.almost_empty = (count_q == CNT_ONE);
    bus.full         = full_w;
    bus.count        = count_q;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (count_q <= CNT_W'(DEPTH));
    end
  end

endmodule
